// File: rtl/line_span_sprite.sv
// Line overlay sprite: a Bresenham walker emits one horizontal span per row into a two-entry buffer, and the pixel path range-compares the raster against the active span.
// Latency: RGB is registered one cycle after hcount_in/vcount_in. The walker needs (span length + 1) cycles per row.
// Backpressure: the walker stalls in EMIT while the next buffer is full. A commit at the end of the active row frees it.
// Optional widening of each displayed span is enabled by defining LINE_SPRITE_WIDEN_EN.
module line_span_sprite #(
  parameter logic [23:0] COLOR    = 24'hFF_FF_FF,
  parameter int          HW       = 11,
  parameter int          VW       = 10,
  parameter int          H_ACTIVE = 1280,
  parameter int          WIDEN    = 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [HW-1:0] hcount_in,
  input  logic [VW-1:0] vcount_in,
  input  logic          new_frame_in,
  input  logic [HW-1:0] x1_in,
  input  logic [HW-1:0] x2_in,
  input  logic [VW-1:0] y1_in,
  input  logic [VW-1:0] y2_in,
  output logic [7:0]    red_out,
  output logic [7:0]    green_out,
  output logic [7:0]    blue_out,
  output logic          done_out
);

  typedef enum logic [1:0] {IDLE, WALK, EMIT, DONE} state_t;

  localparam logic [HW-1:0]        H_END = HW'(H_ACTIVE);
  localparam logic signed [HW+1:0] ZERO  = '0;

  state_t state, state_nxt;

  // walker registers
  logic [HW-1:0]        x, xb, dx, span_min, span_max;
  logic [VW-1:0]        y, yb, dy, row;
  logic                 sx_neg, last;
  logic signed [HW+1:0] err;

  // span buffers
  logic          act_vld, nxt_vld;
  logic [VW-1:0] act_row, nxt_row;
  logic [HW-1:0] act_min, act_max, nxt_min, nxt_max;
  logic [HW-1:0] load_min, load_max;

  // endpoint ordering and initial Bresenham terms
  logic                 swap, sxn_c;
  logic [HW-1:0]        xa_c, xb_c, dx_c;
  logic [VW-1:0]        ya_c, yb_c, dy_c;
  logic signed [HW+1:0] err_c;

  // per-step terms
  logic signed [HW+2:0] e2, dx3, dy3;
  logic signed [HW+1:0] dx2, dy2, err_step;
  logic                 step_x, step_y, at_end, commit, emit_ok, hit;
  logic [HW-1:0]        x_step, cur_min, cur_max;

  // Order the endpoints top to bottom so the walker only ever moves down.
  always_comb begin
    swap  = y2_in < y1_in;
    xa_c  = swap ? x2_in : x1_in;
    xb_c  = swap ? x1_in : x2_in;
    ya_c  = swap ? y2_in : y1_in;
    yb_c  = swap ? y1_in : y2_in;
    sxn_c = xb_c < xa_c;
    dx_c  = sxn_c ? (xa_c - xb_c) : (xb_c - xa_c);
    dy_c  = yb_c - ya_c;
    err_c = $signed({2'b00, dx_c}) - $signed({{(HW+2-VW){1'b0}}, dy_c});
  end

  // One Bresenham step, the running span extent, and the buffer handshake.
  always_comb begin
    dx2      = $signed({2'b00, dx});
    dy2      = $signed({{(HW+2-VW){1'b0}}, dy});
    dx3      = $signed({3'b000, dx});
    dy3      = $signed({{(HW+3-VW){1'b0}}, dy});
    e2       = $signed({err, 1'b0});
    step_x   = e2 >= -dy3;
    step_y   = e2 <= dx3;
    err_step = err - (step_x ? dy2 : ZERO) + (step_y ? dx2 : ZERO);
    x_step   = sx_neg ? (x - 1'b1) : (x + 1'b1);
    at_end   = (x == xb) && (y == yb);
    cur_min  = (x < span_min) ? x : span_min;
    cur_max  = (x > span_max) ? x : span_max;
    commit   = (!act_vld && nxt_vld) ||
               (act_vld && (hcount_in == H_END) && (vcount_in == act_row));
    // A commit in the same cycle wins; the emit simply retries next cycle.
    emit_ok  = (state == EMIT) && !nxt_vld && !commit;
    hit      = act_vld && (vcount_in == act_row) &&
               (hcount_in >= act_min) && (hcount_in <= act_max);
  end

`ifdef LINE_SPRITE_WIDEN_EN
  localparam logic [HW:0] WID = (HW+1)'(WIDEN);
  logic [HW:0] lo_ext, hi_ext;

  // Widen the span as it moves into the active buffer, saturating at both ends.
  always_comb begin
    lo_ext   = {1'b0, nxt_min} - WID;
    hi_ext   = {1'b0, nxt_max} + WID;
    load_min = lo_ext[HW] ? '0 : lo_ext[HW-1:0];
    load_max = hi_ext[HW] ? '1 : hi_ext[HW-1:0];
  end
`else
  assign load_min = nxt_min;
  assign load_max = nxt_max;
  // WIDEN has no effect in this build.
  if (WIDEN < 0) begin : g_widen_ignored
  end
`endif

  // Walker state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a frame pulse restarts the walk from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      WALK:    if (at_end || step_y) state_nxt = EMIT;
      EMIT:    if (emit_ok) state_nxt = last ? DONE : WALK;
      default: state_nxt = state;
    endcase
    if (new_frame_in) state_nxt = WALK;
  end

  // Walker datapath and span buffers; the frame pulse overrides everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x <= '0; xb <= '0; dx <= '0; y <= '0; yb <= '0; dy <= '0; row <= '0;
      sx_neg <= 1'b0; last <= 1'b0; err <= '0;
      span_min <= '0; span_max <= '0;
      act_vld <= 1'b0; act_row <= '0; act_min <= '0; act_max <= '0;
      nxt_vld <= 1'b0; nxt_row <= '0; nxt_min <= '0; nxt_max <= '0;
      done_out <= 1'b0;
    end else if (new_frame_in) begin
      x <= xa_c; xb <= xb_c; dx <= dx_c; y <= ya_c; yb <= yb_c; dy <= dy_c;
      row <= ya_c; sx_neg <= sxn_c; err <= err_c; last <= 1'b0;
      span_min <= xa_c; span_max <= xa_c;
      act_vld <= 1'b0; nxt_vld <= 1'b0; done_out <= 1'b0;
    end else begin
      if (commit) begin
        act_vld <= nxt_vld;
        act_row <= nxt_row;
        act_min <= load_min;
        act_max <= load_max;
        nxt_vld <= 1'b0;
      end
      case (state)
        WALK: begin
          span_min <= cur_min;
          span_max <= cur_max;
          if (at_end) begin
            last <= 1'b1;
          end else begin
            err <= err_step;
            if (step_x) x <= x_step;
            if (step_y) y <= y + 1'b1;
          end
        end
        EMIT: begin
          if (emit_ok) begin
            nxt_vld <= 1'b1;
            nxt_row <= row;
            nxt_min <= span_min;
            nxt_max <= span_max;
            if (last) begin
              done_out <= 1'b1;
            end else begin
              // the next row starts at the x reached by the row-changing step
              span_min <= x;
              span_max <= x;
              row      <= y;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered pixel colour from the active span.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      {red_out, green_out, blue_out} <= '0;
    end else begin
      {red_out, green_out, blue_out} <= hit ? COLOR : 24'h0;
    end
  end

endmodule

// File: tb/tb_line_span_sprite.sv
// Directed bench for line_span_sprite: drives the raster by hand, one row window at a time.
module tb_line_span_sprite;

`ifdef LINE_SPRITE_WIDEN_EN
  localparam int WX = 1;
`else
  localparam int WX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount, x1, x2;
  logic [9:0]  vcount, y1, y2;
  logic        new_frame;
  logic [7:0]  r, g, b;
  logic        done;

  int checks = 0;
  int passed = 0;
  int bad_color = 0;
  int cnt, f, l, tot, fx, lx, diff;
  int xs[21];
  int xs_ref[21];
  int sh_lo[4] = '{100, 102, 105, 109};
  int sh_hi[4] = '{101, 104, 108, 110};
  int fa_lo[3] = '{118, 113, 110};
  int fa_hi[3] = '{120, 117, 112};

  always #5 clk = ~clk;

  line_span_sprite dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .new_frame_in(new_frame), .x1_in(x1), .x2_in(x2), .y1_in(y1), .y2_in(y2),
    .red_out(r), .green_out(g), .blue_out(b), .done_out(done)
  );

  function automatic int elo(int v);
    return (v - WX < 0) ? 0 : v - WX;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // present one raster position, then return just after the edge that registers it
  task automatic drive(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1000);
  endtask

  task automatic frame(input int ax, input int ay, input int bx, input int by);
    x1 = 11'(ax); y1 = 10'(ay); x2 = 11'(bx); y2 = 10'(by);
    new_frame = 1'b1;
    @(posedge clk);
    #1;
    new_frame = 1'b0;
    idle(20);
  endtask

  // sweep hcount over [lo,hi] on row v, then hit the end-of-active-line position
  task automatic scan(input int v, input int lo, input int hi,
                      output int n, output int first, output int lastx);
    n = 0; first = -1; lastx = -1;
    for (int h = lo; h <= hi; h++) begin
      drive(h, v);
      if ({r, g, b} != 24'h0) begin
        n++;
        if (first < 0) first = h;
        lastx = h;
        if ({r, g, b} !== 24'hFFFFFF) bad_color++;
      end
    end
    drive(1280, v);
  endtask

  // rows r0..r0+20 of a steep line: one pixel per row, x never decreasing
  task automatic walk_steep(input string tag, input int r0, input int lo, input int hi,
                            output int first_x, output int last_x);
    int n, a, z, mono_bad, prev;
    mono_bad = 0; prev = -1;
    for (int i = 0; i < 21; i++) begin
      scan(r0 + i, lo, hi, n, a, z);
      check($sformatf("%s_cnt_r%0d", tag, r0 + i), n, 1 + 2 * WX);
      xs[i] = a + WX;
      if (xs[i] < prev) mono_bad++;
      prev = xs[i];
    end
    check($sformatf("%s_mono", tag), mono_bad, 0);
    first_x = xs[0];
    last_x  = xs[20];
  endtask

  initial begin
    rst = 1'b1; new_frame = 1'b0; hcount = '0; vcount = 10'd1000;
    x1 = '0; x2 = '0; y1 = '0; y2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", int'({r, g, b}), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b0;
    scan(0, 0, 10, cnt, f, l);
    check("post_reset_dark", cnt, 0);

    // shallow line
    frame(100, 50, 110, 53);
    check("shallow_done_early", int'(done), 0);
    scan(49, 95, 115, cnt, f, l);
    check("shallow_row49", cnt, 0);
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        idle(3);
        check("shallow_done_before_r53", int'(done), 1);
      end
      scan(50 + i, 95, 115, cnt, f, l);
      check($sformatf("shallow_lo_r%0d", 50 + i), f, elo(sh_lo[i]));
      check($sformatf("shallow_hi_r%0d", 50 + i), l, sh_hi[i] + WX);
      check($sformatf("shallow_contig_r%0d", 50 + i), cnt, l - f + 1);
      tot += cnt;
    end
    check("shallow_total", tot, 11 + 8 * WX);
    scan(54, 95, 115, cnt, f, l);
    check("shallow_row54", cnt, 0);

    // shallow line running right to left
    frame(120, 60, 110, 62);
    for (int i = 0; i < 3; i++) begin
      scan(60 + i, 105, 125, cnt, f, l);
      check($sformatf("leftward_lo_r%0d", 60 + i), f, elo(fa_lo[i]));
      check($sformatf("leftward_hi_r%0d", 60 + i), l, fa_hi[i] + WX);
    end
    check("leftward_done", int'(done), 1);

    // steep line
    frame(200, 10, 203, 30);
    walk_steep("steep", 10, 195, 208, fx, lx);
    check("steep_first_x", fx, 200);
    check("steep_last_x", lx, 203);

    // falling line, then the same line with endpoints given the other way round
    frame(300, 400, 290, 380);
    walk_steep("falling", 380, 285, 305, fx, lx);
    check("falling_first_x", fx, 290);
    check("falling_last_x", lx, 300);
    for (int i = 0; i < 21; i++) xs_ref[i] = xs[i];
    frame(290, 380, 300, 400);
    walk_steep("rising", 380, 285, 305, fx, lx);
    diff = 0;
    for (int i = 0; i < 21; i++) if (xs[i] != xs_ref[i]) diff++;
    check("falling_vs_rising_rows", diff, 0);

    // horizontal line
    frame(400, 200, 410, 200);
    check("horiz_done", int'(done), 1);
    scan(200, 395, 415, cnt, f, l);
    check("horiz_cnt", cnt, 11 + 2 * WX);
    check("horiz_lo", f, elo(400));

    // degenerate point
    frame(500, 500, 500, 500);
    check("point_done", int'(done), 1);
    drive(500, 500);
    check("point_rgb", int'({r, g, b}), 32'hFFFFFF);
    scan(500, 495, 505, cnt, f, l);
    check("point_cnt", cnt, 1 + 2 * WX);

    // new frame in the middle of a walk
    frame(100, 50, 110, 53);
    frame(600, 51, 600, 53);
    scan(50, 95, 115, cnt, f, l);
    check("abort_old_r50", cnt, 0);
    scan(51, 95, 605, cnt, f, l);
    check("abort_r51_cnt", cnt, 1 + 2 * WX);
    check("abort_r51_x", f, elo(600));
    scan(52, 595, 605, cnt, f, l);
    check("abort_r52_x", f, elo(600));

    // asynchronous reset in the middle of a lit row
    frame(700, 100, 700, 102);
    drive(700, 100);
    check("prereset_lit", int'({r, g, b}), 32'hFFFFFF);
    #2 rst = 1'b1;
    #1;
    check("async_reset_rgb", int'({r, g, b}), 0);
    check("async_reset_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tot = 0;
    for (int i = 0; i < 3; i++) begin
      scan(100 + i, 695, 705, cnt, f, l);
      tot += cnt;
    end
    check("after_reset_dark", tot, 0);
    frame(700, 100, 700, 102);
    scan(100, 695, 705, cnt, f, l);
    check("after_reset_relit", f, elo(700));

    // vertical line on the left edge
    frame(0, 5, 0, 7);
    for (int i = 0; i < 3; i++) begin
      scan(5 + i, 0, 4, cnt, f, l);
      check($sformatf("edge_lo_r%0d", 5 + i), f, 0);
      check($sformatf("edge_hi_r%0d", 5 + i), l, WX);
    end

    check("colour_exact", bad_color, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/line_span_sprite.md
# line_span_sprite

All-octant line overlay for the video pipeline. A Bresenham walker computes one horizontal pixel span per scanline and buffers it one row ahead of the raster. The pixel path then reduces to a range compare against `hcount_in`/`vcount_in`. It sits beside the other sprites, and its RGB is OR-composited downstream. Steep, shallow, rising and falling lines all render without gaps.

## Interface
- `COLOR`, 24'hFF_FF_FF: RGB888 line colour.
- `HW`, 11: width of the x and hcount signals.
- `VW`, 10: width of the y and vcount signals.
- `H_ACTIVE`, 1280: active pixels per line.
- `WIDEN`, 1: extra pixels added on each side of every span; used only with the macro.
- `clk_in`, input, 1: pixel clock.
- `rst_in`, input, 1: reset, asynchronous, active-high.
- `hcount_in`, input, HW: raster x.
- `vcount_in`, input, VW: raster y.
- `new_frame_in`, input, 1: one-cycle pulse at the start of vertical blanking; samples the endpoints.
- `x1_in`, `x2_in`, input, HW: endpoint x, unsigned.
- `y1_in`, `y2_in`, input, VW: endpoint y, unsigned.
- `red_out`, `green_out`, `blue_out`, output, 8 each: pixel colour, registered.
- `done_out`, output, 1: high once the walker has emitted the span containing the final endpoint of the current frame.

## Operation
- **Latch (`new_frame_in`)**
  - Order the endpoints so that ya ≤ yb; swap the x values together with the y values.
  - dx = |xb − xa|, dy = yb − ya, sx = +1 if xb ≥ xa, else −1.
  - err = dx − dy, signed HW+2 bits; e2 = 2·err, signed HW+3 bits.
  - Clear the active and next buffers and `done_out`. This aborts any walk in progress.
- **Walker FSM**
  - IDLE → WALK on `new_frame_in`.
  - WALK: one Bresenham step per cycle.
    - Track the span minimum and maximum x for the current row.
    - If e2 ≥ −dy: err −= dy, x += sx.
    - If e2 ≤ dx: err += dx, y += 1.
  - When y increments, or the endpoint (xb, yb) is reached, go to EMIT.
  - EMIT: write {row, xmin, xmax} into the next buffer if it is empty; otherwise stall in EMIT.
    - If the emitted row contains the endpoint: go to DONE and set `done_out`.
    - Otherwise: go back to WALK on the next row, seeded with the current x.
  - DONE: hold until `new_frame_in`.
- **Buffers**
  - Active buffer {valid, row, xmin, xmax} and next buffer {valid, row, xmin, xmax}.
  - Commit (active ← next, next.valid ← 0) happens when:
    - active is invalid and next is valid, or
    - `hcount_in` == H_ACTIVE, `vcount_in` == active.row, and active is valid (end of the row's active portion). If next is invalid at that moment, active becomes invalid.
- **Pixel path**
  - Output is hit = active.valid, `vcount_in` == active.row, and xmin ≤ `hcount_in` ≤ xmax.
  - On a hit, RGB = COLOR; otherwise RGB = 0.
- **Boundary conditions**
  - Equal endpoints: one span with xmin = xmax, then DONE.
  - Horizontal line: one span covering the full x range.
  - Vertical line: one pixel per row.
  - Rows ≥ the visible height are never displayed. The walker stalls in EMIT until the next `new_frame_in`.

## Timing
- Reset values, applied asynchronously: RGB = 0, `done_out` = 0, FSM = IDLE, both buffers invalid.
- Pixel latency is one cycle: the RGB reflects the `hcount_in`/`vcount_in` of the previous cycle.
- Walker cost per row is (span length + 1) cycles, at most H_ACTIVE + 1, which is less than one line period.
  - Row r+1 is therefore in the next buffer before row r's commit point.
  - The first row is computed during vertical blanking.
- `new_frame_in` takes priority over every walker and commit action in the same cycle.
- A commit and an EMIT in the same cycle: the commit wins, and the EMIT retries on the next cycle.
- Reset asserted mid-frame: no output until the first `new_frame_in` after release.

## Configuration
- `LINE_SPRITE_WIDEN_EN` defined:
  - The span loaded into the active buffer is widened to [xmin − WIDEN, xmax + WIDEN].
  - Both ends saturate to [0, 2^HW − 1].
- Undefined:
  - The span is exactly xmin..xmax.
  - `WIDEN` is ignored and no widening logic is built.

## Test plan
- Shallow line (100,50)→(110,53) -> rows 50..53 lit, spans contiguous and non-overlapping, 11 pixels total, `done_out` high before row 53 displays.
- Steep line (200,10)→(203,30) -> exactly one pixel on each of rows 10..30, x non-decreasing from 200 to 203.
- Falling line x1 > x2 and y1 > y2, (300,400)→(290,380) -> same pixels as (290,380)→(300,400).
- Degenerate (500,500)→(500,500) -> only pixel (500,500) lit in COLOR, one cycle after the matching hcount.
- `new_frame_in` mid-walk with new endpoints -> old spans are never shown in the new frame. Async reset mid-line -> RGB 0 in the same cycle, and it stays 0 until the next frame pulse.
- With `LINE_SPRITE_WIDEN_EN` and WIDEN = 1, vertical line at x = 0 -> each row lit at x = 0..1, with the low end saturated.
